cacheline_adaptor: RTL

- Responder on the cache-to-physical-memory line interface: serves 256-bit line reads and writes issued by the instruction and data caches.
- Converts each line request into a 4-beat, 64-bit burst on the physical memory port.
- Sits between the cache/arbiter and the burst memory model; one transaction in flight at a time.

---
 rtl/cacheline_adaptor_if.sv | 27 ++
 rtl/cacheline_adaptor.sv | 82 ++++++++
 2 files changed

// File: rtl/cacheline_adaptor_if.sv
// Line-request side (cache/arbiter) and burst side (physical memory) of the
// cacheline adaptor, bundled so the adaptor and its environment share one port.
interface cacheline_adaptor_if;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    // slave: the adaptor itself; master: the cache plus memory model around it
    modport slave (
        input  pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
        output pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
    );
    modport master (
        output pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
        input  pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit line read/write into a 4-beat 64-bit memory burst,
// one transaction in flight, with a single-cycle completion pulse.
module cacheline_adaptor #(
    parameter int s_offset  = 5,
    parameter int s_beat    = 64,
    parameter int num_beats = 4
) (
    input  logic          clk,
    input  logic          rst,
    cacheline_adaptor_if.slave bus
);
    localparam int s_line = 8 * (2 ** s_offset);
    localparam int CNT_W  = $clog2(num_beats);
    localparam int BIT_W  = $clog2(s_line);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_BURST = 2'd1;
    localparam logic [1:0] WR_BURST = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       addr;
    logic [s_line-1:0] line;
    logic [s_line-1:0] wline;
    logic [s_line-1:0] rdata;
    logic [BIT_W-1:0]  beat_lsb;
    logic              last_beat;
    logic              unused_offset;

    assign beat_lsb      = BIT_W'(cnt) << $clog2(s_beat);
    assign last_beat     = (cnt == CNT_W'(num_beats - 1));
    assign unused_offset = ^bus.pmem_address[s_offset-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            line  <= '0;
            wline <= '0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // read wins if both are raised; the write data is not taken
                    if (bus.pmem_read) begin
                        addr  <= {bus.pmem_address[31:s_offset], {s_offset{1'b0}}};
                        cnt   <= '0;
                        state <= RD_BURST;
                    end else if (bus.pmem_write) begin
                        addr  <= {bus.pmem_address[31:s_offset], {s_offset{1'b0}}};
                        wline <= bus.pmem_wdata;
                        cnt   <= '0;
                        state <= WR_BURST;
                    end
                end
                RD_BURST: if (bus.burst_resp) begin
                    line[beat_lsb +: s_beat] <= bus.burst_rdata;
                    cnt <= cnt + 1'b1;
                    if (last_beat) begin
                        // final beat lands in the top word; publish the whole line now
                        rdata <= {bus.burst_rdata, line[s_line-s_beat-1:0]};
                        state <= DONE;
                    end
                end
                WR_BURST: if (bus.burst_resp) begin
                    cnt <= cnt + 1'b1;
                    if (last_beat) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.burst_address = addr;
    assign bus.burst_read    = (state == RD_BURST);
    assign bus.burst_write   = (state == WR_BURST);
    assign bus.burst_wdata   = (state == WR_BURST) ? wline[beat_lsb +: s_beat] : '0;
    assign bus.pmem_resp     = (state == DONE);
    assign bus.pmem_rdata    = rdata;
endmodule
